// File: rtl/ibex_rf_write_arbiter.sv
// Arbitrates the register file write port between the execute stage and a small
// load/store writeback FIFO, and tracks pending loads to stall dependent reads.
module ibex_rf_write_arbiter #(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned LsuFifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_we_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_we_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_ready_o,
  input  logic                 lsu_issue_i,
  input  logic [4:0]           lsu_issue_addr_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 reg_stall_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam int unsigned AddrBits = RV32E ? 4 : 5;
  localparam int unsigned PtrW     = $clog2(LsuFifoDepth);
  localparam int unsigned CntW     = PtrW + 1;

  // The reduced register file ignores address bit 4 everywhere.
  function automatic logic [4:0] mask_addr(input logic [4:0] a);
    mask_addr = a;
    if (RV32E) mask_addr[4] = 1'b0;
  endfunction

  logic [4:0] ra, rb, exa, isa, lsa;
  assign ra  = mask_addr(raddr_a_i);
  assign rb  = mask_addr(raddr_b_i);
  assign exa = mask_addr(ex_waddr_i);
  assign isa = mask_addr(lsu_issue_addr_i);
  assign lsa = mask_addr(lsu_waddr_i);

  logic [4:0]           fifo_addr_q [LsuFifoDepth];
  logic [DataWidth-1:0] fifo_data_q [LsuFifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [NumWords-1:0]  pending_q, pending_d;

  logic                 full, empty, push, pop, head_grant, ex_grant;
  logic [4:0]           head_addr;
  logic [DataWidth-1:0] head_data;

  assign full      = (count_q == CntW'(LsuFifoDepth));
  assign empty     = (count_q == '0);
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // A full FIFO takes priority so load writebacks cannot starve.
  assign head_grant = !empty && (full || !ex_we_i);
  assign ex_grant   = ex_we_i && !full;
  assign push       = lsu_we_i && !full;
  assign pop        = head_grant;

  assign ex_ready_o  = !full;
  assign lsu_ready_o = !full;

  // pending_q[0] is held at zero, so address-0 terms never stall.
  assign reg_stall_o = pending_q[ra[AddrBits-1:0]]
                     | pending_q[rb[AddrBits-1:0]]
                     | (ex_we_i & pending_q[exa[AddrBits-1:0]])
                     | (lsu_issue_i & pending_q[isa[AddrBits-1:0]]);

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = empty ? 5'd0 : head_addr;
    rf_wdata_o = empty ? '0 : head_data;
    if (head_grant) begin
      rf_we_o = (head_addr != 5'd0);
    end else if (ex_grant) begin
      rf_we_o    = (exa != 5'd0);
      rf_waddr_o = exa;
      rf_wdata_o = ex_wdata_i;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (head_grant && head_addr != 5'd0) pending_d[head_addr[AddrBits-1:0]] = 1'b0;
    if (lsu_issue_i && !reg_stall_o && isa != 5'd0) pending_d[isa[AddrBits-1:0]] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= lsa;
      fifo_data_q[wr_ptr_q] <= lsu_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Bench for ibex_rf_write_arbiter: directed test-plan scenarios plus random traffic,
// all checked against a queue-based model of the writeback rules.
module tb_ibex_rf_write_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, ex_we, lsu_we, lsu_issue;
  logic [4:0]  ex_waddr, lsu_waddr, lsu_issue_addr, raddr_a, raddr_b;
  logic [31:0] ex_wdata, lsu_wdata;
  logic        ex_ready, lsu_ready, reg_stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        e_rst, e_ex_we, e_lsu_we, e_lsu_issue;
  logic [4:0]  e_ex_waddr, e_lsu_waddr, e_lsu_issue_addr, e_raddr_a, e_raddr_b;
  logic [31:0] e_ex_wdata, e_lsu_wdata;
  logic        e_ex_ready, e_lsu_ready, e_reg_stall, e_rf_we;
  logic [4:0]  e_rf_waddr;
  logic [31:0] e_rf_wdata;

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  ibex_rf_write_arbiter #(.RV32E(1'b0), .DataWidth(32), .LsuFifoDepth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready),
    .lsu_issue_i(lsu_issue), .lsu_issue_addr_i(lsu_issue_addr),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .reg_stall_o(reg_stall),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata)
  );

  ibex_rf_write_arbiter #(.RV32E(1'b1), .DataWidth(32), .LsuFifoDepth(DEPTH)) dut_e (
    .clk_i(clk), .rst_i(e_rst),
    .ex_we_i(e_ex_we), .ex_waddr_i(e_ex_waddr), .ex_wdata_i(e_ex_wdata), .ex_ready_o(e_ex_ready),
    .lsu_we_i(e_lsu_we), .lsu_waddr_i(e_lsu_waddr), .lsu_wdata_i(e_lsu_wdata),
    .lsu_ready_o(e_lsu_ready),
    .lsu_issue_i(e_lsu_issue), .lsu_issue_addr_i(e_lsu_issue_addr),
    .raddr_a_i(e_raddr_a), .raddr_b_i(e_raddr_b), .reg_stall_o(e_reg_stall),
    .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata)
  );

  // scoreboard: expected FIFO contents and pending registers
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t      exp_q[$];
  bit [31:0] pend;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic idle();
    ex_we = 0; ex_waddr = 0; ex_wdata = 0;
    lsu_we = 0; lsu_waddr = 0; lsu_wdata = 0;
    lsu_issue = 0; lsu_issue_addr = 0; raddr_a = 0; raddr_b = 0;
  endtask

  // Check one cycle of the main DUT against the model, then advance both.
  task automatic cycle();
    ent_t        head;
    bit          full, empty;
    int          grant;
    logic        exp_stall, exp_we;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    #1;
    full  = (exp_q.size() == DEPTH);
    empty = (exp_q.size() == 0);
    head  = empty ? '0 : exp_q[0];
    exp_stall = (raddr_a != 0 && pend[raddr_a]) || (raddr_b != 0 && pend[raddr_b])
             || (ex_we && ex_waddr != 0 && pend[ex_waddr])
             || (lsu_issue && lsu_issue_addr != 0 && pend[lsu_issue_addr]);
    if (!empty && full)  grant = 2;
    else if (ex_we)      grant = 1;
    else if (!empty)     grant = 2;
    else                 grant = 0;
    exp_we = 1'b0;
    exp_a  = head.a;
    exp_d  = head.d;
    if (grant == 1) begin
      exp_we = (ex_waddr != 0); exp_a = ex_waddr; exp_d = ex_wdata;
    end else if (grant == 2) begin
      exp_we = (head.a != 0);
    end
    check_eq("rf_we", 64'(rf_we), 64'(exp_we));
    check_eq("rf_waddr", 64'(rf_waddr), 64'(exp_a));
    check_eq("rf_wdata", 64'(rf_wdata), 64'(exp_d));
    check_eq("ex_ready", 64'(ex_ready), 64'(!full));
    check_eq("lsu_ready", 64'(lsu_ready), 64'(!full));
    check_eq("reg_stall", 64'(reg_stall), 64'(exp_stall));
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      pend = '0;
    end else begin
      if (grant == 2) begin
        if (head.a != 0) pend[head.a] = 1'b0;
        void'(exp_q.pop_front());
      end
      if (lsu_issue && !exp_stall && lsu_issue_addr != 0) pend[lsu_issue_addr] = 1'b1;
      if (lsu_we && !full) exp_q.push_back('{a: lsu_waddr, d: lsu_wdata});
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; e_rst = 1; idle();
    e_ex_we = 0; e_ex_waddr = 0; e_ex_wdata = 0; e_lsu_we = 0; e_lsu_waddr = 0;
    e_lsu_wdata = 0; e_lsu_issue = 0; e_lsu_issue_addr = 0; e_raddr_a = 0; e_raddr_b = 0;
    exp_q.delete(); pend = '0;
    @(posedge clk); @(negedge clk);

    // RV32E: address 0x13 aliases r3
    e_rst = 0;
    e_lsu_issue = 1; e_lsu_issue_addr = 5'h13;
    #1 check_eq("e_stall_before", 64'(e_reg_stall), 64'd0);
    @(negedge clk);
    e_lsu_issue = 0; e_raddr_a = 5'd3;
    #1 check_eq("e_stall_r3", 64'(e_reg_stall), 64'd1);
    e_raddr_a = 5'h13;
    #1 check_eq("e_stall_r13", 64'(e_reg_stall), 64'd1);
    e_raddr_a = 5'd4;
    #1 check_eq("e_stall_r4", 64'(e_reg_stall), 64'd0);
    e_lsu_we = 1; e_lsu_waddr = 5'h13; e_lsu_wdata = 32'h0000_abcd;
    #1 check_eq("e_rf_we_push", 64'(e_rf_we), 64'd0);
    @(negedge clk);
    e_lsu_we = 0; e_raddr_a = 5'd3;
    #1;
    check_eq("e_rf_we", 64'(e_rf_we), 64'd1);
    check_eq("e_rf_waddr", 64'(e_rf_waddr), 64'd3);
    check_eq("e_rf_wdata", 64'(e_rf_wdata), 64'h0000_abcd);
    check_eq("e_stall_commit", 64'(e_reg_stall), 64'd1);
    @(negedge clk);
    #1;
    check_eq("e_stall_after", 64'(e_reg_stall), 64'd0);
    check_eq("e_rf_we_after", 64'(e_rf_we), 64'd0);

    // reset state of the main DUT
    cycle(); cycle();
    rst = 0;

    // load r5, data three cycles later, idle execute stage
    lsu_issue = 1; lsu_issue_addr = 5'd5; raddr_a = 5'd5; raddr_b = 5'd6;
    cycle();
    lsu_issue = 0;
    cycle(); cycle();
    lsu_we = 1; lsu_waddr = 5'd5; lsu_wdata = 32'h5555_0005;
    cycle();
    lsu_we = 0;
    #1 check_eq("r5_stall_commit", 64'(reg_stall), 64'd1);
    cycle();
    #1 check_eq("r5_stall_dropped", 64'(reg_stall), 64'd0);
    cycle();
    idle();

    // execute every cycle while two loads arrive
    for (int i = 0; i < 7; i++) begin
      ex_we = 1; ex_waddr = 5'(8 + i); ex_wdata = 32'hE000_0000 + 32'(i);
      lsu_we = (i < 2); lsu_waddr = 5'(20 + i); lsu_wdata = 32'hA000_0000 + 32'(i);
      if (i == 2) begin
        #1 check_eq("full_ex_ready", 64'(ex_ready), 64'd0);
        check_eq("full_head_addr", 64'(rf_waddr), 64'd20);
      end
      cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) cycle();

    // write-after-write on pending r7
    lsu_issue = 1; lsu_issue_addr = 5'd7;
    cycle();
    lsu_issue = 0; ex_we = 1; ex_waddr = 5'd7; ex_wdata = 32'h7777_0000;
    #1 check_eq("waw_stall", 64'(reg_stall), 64'd1);
    cycle();
    ex_we = 0; lsu_we = 1; lsu_waddr = 5'd7; lsu_wdata = 32'h7777_1111;
    cycle();
    lsu_we = 0;
    cycle();
    ex_we = 1; ex_waddr = 5'd7; ex_wdata = 32'h7777_2222;
    #1 check_eq("waw_released", 64'(reg_stall), 64'd0);
    cycle();
    idle();

    // address 0 from both sources
    ex_we = 1; ex_waddr = 5'd0; ex_wdata = 32'hdead_0000;
    lsu_we = 1; lsu_waddr = 5'd0; lsu_wdata = 32'hdead_0001;
    cycle();
    lsu_waddr = 5'd0; lsu_wdata = 32'hdead_0002;
    cycle();
    lsu_we = 0;
    for (int i = 0; i < 3; i++) cycle();
    ex_we = 0;
    for (int i = 0; i < 2; i++) cycle();
    check_eq("zero_drained", 64'(lsu_ready), 64'd1);

    // reset with two buffered entries and pending r3
    lsu_issue = 1; lsu_issue_addr = 5'd3;
    cycle();
    lsu_issue = 0; ex_we = 1; ex_waddr = 5'd9;
    lsu_we = 1; lsu_waddr = 5'd3; lsu_wdata = 32'h3333_0001;
    cycle();
    lsu_waddr = 5'd4; lsu_wdata = 32'h4444_0002;
    cycle();
    idle(); rst = 1;
    cycle();
    rst = 0; raddr_a = 5'd3;
    #1;
    check_eq("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    check_eq("rst_stall_r3", 64'(reg_stall), 64'd0);
    check_eq("rst_no_write", 64'(rf_we), 64'd0);
    cycle();
    idle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      ex_we          = $urandom_range(0, 1);
      ex_waddr       = 5'($urandom_range(0, 9));
      ex_wdata       = $urandom;
      lsu_we         = ($urandom_range(0, 2) == 0);
      lsu_waddr      = 5'($urandom_range(0, 9));
      lsu_wdata      = $urandom;
      lsu_issue      = ($urandom_range(0, 3) == 0);
      lsu_issue_addr = 5'($urandom_range(0, 9));
      raddr_a        = 5'($urandom_range(0, 31));
      raddr_b        = 5'($urandom_range(0, 9));
      cycle();
    end
    rst = 0; idle();
    for (int i = 0; i < 4; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_rf_write_arbiter.md
# ibex_rf_write_arbiter

Shares the register file's single write port between the execute stage and the load/store unit. The load/store unit's writebacks go through a small FIFO. A pending-load scoreboard produces the register-read stall that keeps dependent instructions from reading stale data. The block sits between the writeback sources and the register file's write port W1.

## Interface
Parameters:
- RV32E, 0, 1 selects a 16-entry scoreboard and uses address bits [3:0] only. Bit 4 is ignored.
- DataWidth, 32, width of the write data.
- LsuFifoDepth, 2, number of load/store writeback buffer entries (power of two, at least 2).

Ports:
- clk_i  in  1  clock. All state updates on its rising edge.
- rst_i  in  1  reset. Synchronous and active-high.
- ex_we_i  in  1  execute stage requests a register write.
- ex_waddr_i  in  5  execute destination register.
- ex_wdata_i  in  DataWidth  execute write data.
- ex_ready_o  out  1  execute write accepted this cycle. Low only while the FIFO is full.
- lsu_we_i  in  1  load/store unit pushes a writeback.
- lsu_waddr_i  in  5  load destination register.
- lsu_wdata_i  in  DataWidth  load data.
- lsu_ready_o  out  1  FIFO can accept a push (not full).
- lsu_issue_i  in  1  a load targeting lsu_issue_addr_i is issued.
- lsu_issue_addr_i  in  5  destination of the issued load.
- raddr_a_i, raddr_b_i  in  5 each  decode-stage read addresses.
- reg_stall_o  out  1  decode must hold.
- rf_we_o  out  1  register file write enable.
- rf_waddr_o  out  5  register file write address.
- rf_wdata_o  out  DataWidth  register file write data.

## Operation
- Scoreboard: one pending bit per register index 1..NUM_WORDS-1. Register 0 is never pending.
- Set: lsu_issue_i and !reg_stall_o and address != 0 sets the pending bit at the next edge.
- Clear: the bit clears at the edge ending the cycle in which a FIFO entry with that address drives rf_we_o.
- reg_stall_o is the OR of the following, each checked against the registered pending bits:
  - pending[raddr_a_i]
  - pending[raddr_b_i]
  - ex_we_i and pending[ex_waddr_i] (write-after-write)
  - lsu_issue_i and pending[lsu_issue_addr_i] (no double-pending)
- Any address 0 term contributes 0.
- FIFO: a push happens when lsu_we_i and lsu_ready_o. The head pops when it is granted the port.
- Arbitration, evaluated each cycle:
  - FIFO full and not empty: the FIFO head wins and ex_ready_o = 0.
  - Otherwise, if ex_we_i: the execute stage wins, ex_ready_o = 1, and the head waits.
  - Otherwise, if the FIFO is not empty: the head wins.
- Address 0 writes from either source are consumed but force rf_we_o = 0. A FIFO entry with address 0 still pops.
- When no source is granted: rf_we_o = 0, and rf_waddr_o / rf_wdata_o hold the FIFO head, or zero if the FIFO is empty.
- Reset: the FIFO is emptied and all pending bits are cleared. Reset mid-operation discards buffered loads with no write.

## Timing
- Output values during and after reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, ex_ready_o=1, lsu_ready_o=1, reg_stall_o=0 (given idle inputs).
- Execute write: zero latency. The grant and rf_we_o are combinational in the same cycle.
- Load/store write: a push in cycle N appears on rf_we_o no earlier than N+1.
- Pending-bit timing for a load whose data commits in cycle M: reg_stall_o for that register remains high in M and drops in M+1.
- Push when full is impossible, because lsu_ready_o=0 even if a pop occurs that cycle. A push and a pop in the same non-full cycle keep the count unchanged.
- Pointers wrap modulo LsuFifoDepth.
- Issue and clear on different indices in the same cycle both take effect.

## Test plan
- Load r5 issued, data pushed 3 cycles later with an idle execute stage -> reg_stall_o high for raddr_a_i=5 until the cycle after rf_we_o=1/rf_waddr_o=5. r6 is never stalled.
- Execute writes every cycle while 2 load/store pushes arrive -> the execute stage wins until the FIFO is full. Then ex_ready_o=0 for exactly one cycle and the head commits. Order is preserved.
- Execute write to r7 while r7 is pending -> reg_stall_o=1. After the load commits, the write proceeds.
- Writes to address 0 from both sources -> rf_we_o stays 0, and the FIFO still drains.
- Reset asserted with 2 buffered entries and pending r3 -> next cycle the FIFO is empty, lsu_ready_o=1, reg_stall_o=0 for raddr 3, and no write occurs.
- RV32E=1, issue to address 0x13 -> treated as r3.
